// File: rtl/mac_pkg.sv
// Shared widths and wrap-around add for the MAC datapath.
package mac_pkg;

    localparam int MAC_IN_W  = 8;
    localparam int MAC_ACC_W = 16;

    // The result width is what truncates the sum, so the carry out is dropped.
    function automatic logic [MAC_ACC_W-1:0] mac_add_wrap(
        input logic [MAC_ACC_W-1:0] acc,
        input logic [MAC_ACC_W-1:0] prod
    );
        return acc + prod;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational unsigned IN_W x IN_W multiplier with a full-width product.
module mac_mult #(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0]   a,
    input  logic [IN_W-1:0]   b,
    output logic [2*IN_W-1:0] p
);

    always_comb begin
        p = (2*IN_W)'(a) * (2*IN_W)'(b);
    end

endmodule

// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate: acc <= acc + A*B on every edge, modulo 2^ACC_W.
module mac_unit
    import mac_pkg::*;
#(
    parameter int IN_W  = MAC_IN_W,
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    output logic [ACC_W-1:0] Acc_out
);

    generate
        if (ACC_W < 2*IN_W) begin : g_width_check
            $error("mac_unit: ACC_W (%0d) must be >= 2*IN_W (%0d)", ACC_W, 2*IN_W);
        end
    endgenerate

    logic [2*IN_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  acc_q;

    mac_mult #(.IN_W(IN_W)) u_mult (
        .a (A),
        .b (B),
        .p (prod)
    );

    assign prod_ext = ACC_W'(prod);

    // Use the shared adder at the package width; any other width wraps natively.
    generate
        if (ACC_W == MAC_ACC_W) begin : g_pkg_add
            assign sum = mac_add_wrap(acc_q, prod_ext);
        end else begin : g_local_add
            assign sum = acc_q + prod_ext;
        end
    endgenerate

    always_comb begin
        acc_d = sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign Acc_out = acc_q;

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: the driver queues the expected accumulator per edge.
module tb_mac_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] Acc_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];

    mac_unit #(.IN_W(8), .ACC_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .Acc_out (Acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation is consumed per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (Acc_out !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %0d expected %0d", e.name, Acc_out, e.exp);
                end
            end
        end
    end

    task automatic step(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
        exp_t e;
        @(negedge clk);
        A = a;
        B = b;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [15:0] exp);
        total++;
        if (Acc_out !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, Acc_out, exp);
        end
    endtask

    // Asynchronous pulse between edges; accumulator must clear before any edge.
    task automatic async_reset_pulse(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_now(name, 16'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] model;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          wait_cnt;

        rst = 1'b1;
        A   = 8'd0;
        B   = 8'd0;
        #1;
        check_now("reset_immediate", 16'd0);

        // Reset holds the accumulator at zero regardless of operands.
        step("reset_zero_ops", 8'd0, 8'd0, 16'd0);
        step("reset_hold_ops", 8'd5, 8'd3, 16'd0);
        step("reset_hold_ops2", 8'd5, 8'd3, 16'd0);

        @(negedge clk);
        rst = 1'b0;
        A   = 8'd5;
        B   = 8'd3;
        begin
            exp_t e;
            e.name = "acc_first";
            e.exp  = 16'd15;
            sb_q.push_back(e);
        end
        step("acc_second", 8'd4, 8'd6, 16'd39);
        step("acc_third", 8'd5, 8'd4, 16'd59);

        step("hold_0", 8'd0, 8'd200, 16'd59);
        step("hold_1", 8'd0, 8'd200, 16'd59);
        step("hold_2", 8'd0, 8'd200, 16'd59);
        step("hold_b0", 8'd77, 8'd0, 16'd59);

        async_reset_pulse("async_clear");
        A = 8'd2;
        B = 8'd2;
        begin
            exp_t e;
            e.name = "after_async";
            e.exp  = 16'd4;
            sb_q.push_back(e);
        end

        async_reset_pulse("async_clear2");
        A = 8'd255;
        B = 8'd255;
        begin
            exp_t e;
            e.name = "wrap_first";
            e.exp  = 16'd65025;
            sb_q.push_back(e);
        end
        step("wrap_second", 8'd255, 8'd255, 16'd64514);

        // Random run against an independent modulo-2^16 model.
        model = 16'd64514;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            model = 16'((32'(model) + 32'(ra) * 32'(rb)) % 65536);
            step("random", ra, rb, model);
        end

        step("final_hold", 8'd0, 8'd0, model);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
